// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=3 convolutional encoder with two zero tail bits per frame.
// Coded bits leave serially, c0 then c1, with start/end-of-frame markers.
module conv_encoder_framer #(
  parameter int unsigned FRAME_LEN = 14,
  parameter logic [2:0]  G0        = 3'b111,
  parameter logic [2:0]  G1        = 3'b101
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  output logic out_sof,
  output logic out_eof,
  output logic busy
);

  typedef enum logic [1:0] {WAIT, E0, E1} state_t;

  localparam logic [7:0] FRAME_LEN_W = 8'(FRAME_LEN);

  state_t     state;
  logic [1:0] sr;            // {s1, s0}; s1 is the previous input bit
  logic [7:0] icnt;
  logic       tcnt;
  logic       c1_hold;
  logic       eof_pending;

  logic       frame_full;
  logic       accept;
  logic       tail_step;
  logic       do_encode;
  logic       enc_bit;
  logic [2:0] w;
  logic       c0;
  logic       c1;

  // in_ready depends only on registered state, never on in_valid.
  assign frame_full = (icnt == FRAME_LEN_W);
  assign in_ready   = (state != E0) && (icnt < FRAME_LEN_W);
  assign accept     = in_valid && in_ready;

  // out_eof is only high in E1 of the second tail bit, so it marks frame end.
  assign tail_step  = (state == E1) && frame_full && !out_eof;
  assign do_encode  = accept || tail_step;

  assign enc_bit    = accept ? in_bit : 1'b0;
  assign w          = {enc_bit, sr};
  assign c0         = ^(w & G0);
  assign c1         = ^(w & G1);

  // NOTE: non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= WAIT;
      sr          <= '0;
      icnt        <= '0;
      tcnt        <= 1'b0;
      c1_hold     <= 1'b0;
      eof_pending <= 1'b0;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      busy        <= 1'b0;
    end else if (do_encode) begin
      out_bit   <= c0;
      c1_hold   <= c1;
      sr        <= {enc_bit, sr[1]};
      out_valid <= 1'b1;
      out_sof   <= accept && (icnt == '0);
      out_eof   <= 1'b0;
      busy      <= 1'b1;
      state     <= E0;
      if (accept) begin
        icnt <= icnt + 8'd1;
      end else begin
        eof_pending <= tcnt;
        tcnt        <= tcnt + 1'b1;
      end
    end else begin
      unique case (state)
        E0: begin
          out_bit <= c1_hold;
          out_sof <= 1'b0;
          out_eof <= eof_pending;
          state   <= E1;
        end
        E1: begin
          out_valid <= 1'b0;
          out_eof   <= 1'b0;
          state     <= WAIT;
          // Frame complete: trellis is back at zero; otherwise starvation keeps sr/icnt.
          if (out_eof) begin
            busy        <= 1'b0;
            sr          <= '0;
            icnt        <= '0;
            tcnt        <= 1'b0;
            eof_pending <= 1'b0;
          end
        end
        default: begin
          state <= WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Self-checking bench for conv_encoder_framer: a cycle-scheduled stream model
// predicts every output, plus literal frame images for the directed cases.
module tb_conv_encoder_framer;

  localparam int         FL = 14;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_bit = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, out_bit, out_valid, out_sof, out_eof, busy;

  int n_checks = 0;
  int n_errors = 0;

  conv_encoder_framer #(.FRAME_LEN(FL), .G0(G0), .G1(G1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_bit  (out_bit),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .out_eof  (out_eof),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected output per cycle, kept in an 8-slot schedule indexed by cycle.
  bit sv[8], sb[8], ss[8], se[8];
  bit m_bits[0:FL+1];
  int cyc = 0;
  int m_icnt = 0;
  bit m_busy = 0;
  int slot, k;
  bit exp_ready, acc;

  // Capture of the DUT stream, frame by frame.
  logic [31:0] cap = '0, last_frame = '0;
  int cap_n = 0, last_len = 0, frames_done = 0;
  int idle_in_frame = 0, last_idle = 0, gap_cnt = 0, last_gap = 0;
  bit in_frame = 0;

  // Coded bit for frame position idx (tails read as zero) from the generator taps.
  function automatic bit coded(input int idx, input bit second);
    logic [2:0] g;
    bit v;
    g = second ? G1 : G0;
    v = 1'b0;
    for (int j = 0; j < 3; j++)
      if (g[2-j] && (idx - j) >= 0 && (idx - j) < FL) v ^= m_bits[idx-j];
    return v;
  endfunction

  task automatic sched(input int c, input bit b, input bit s, input bit e);
    int i;
    i = c % 8;
    sv[i] = 1'b1; sb[i] = b; ss[i] = s; se[i] = e;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_bit",   32'(out_bit),   32'd0);
      check("rst_out_sof",   32'(out_sof),   32'd0);
      check("rst_out_eof",   32'(out_eof),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      for (int i = 0; i < 8; i++) begin sv[i] = 0; ss[i] = 0; se[i] = 0; end
      cyc = 0; m_icnt = 0; m_busy = 0; in_frame = 0; gap_cnt = 0;
    end else begin
      slot      = cyc % 8;
      exp_ready = (m_icnt < FL) && !sv[(cyc + 1) % 8];
      check("in_ready",  32'(in_ready),  32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(sv[slot]));
      if (sv[slot]) check("out_bit", 32'(out_bit), 32'(sb[slot]));
      check("out_sof",   32'(out_sof),   32'(sv[slot] && ss[slot]));
      check("out_eof",   32'(out_eof),   32'(sv[slot] && se[slot]));
      check("busy",      32'(busy),      32'(m_busy));

      if (out_valid) begin
        if (out_sof) begin
          cap = '0; cap_n = 0; in_frame = 1; idle_in_frame = 0; last_gap = gap_cnt;
        end
        cap = {cap[30:0], out_bit};
        cap_n++;
        if (out_eof) begin
          last_frame = cap; last_len = cap_n; last_idle = idle_in_frame;
          frames_done++; in_frame = 0; gap_cnt = 0;
        end
      end else begin
        if (in_frame) idle_in_frame++;
        gap_cnt++;
      end

      if (sv[slot] && se[slot]) begin m_icnt = 0; m_busy = 0; end
      sv[slot] = 0; ss[slot] = 0; se[slot] = 0;

      acc = in_valid && exp_ready;
      if (acc) begin
        k = m_icnt;
        m_bits[k] = in_bit;
        sched(cyc + 1, coded(k, 0), k == 0, 0);
        sched(cyc + 2, coded(k, 1), 0, 0);
        m_icnt++;
        m_busy = 1;
        if (m_icnt == FL) begin
          sched(cyc + 3, coded(FL, 0), 0, 0);
          sched(cyc + 4, coded(FL, 1), 0, 0);
          sched(cyc + 5, coded(FL + 1, 0), 0, 0);
          sched(cyc + 6, coded(FL + 1, 1), 0, 1);
        end
      end
      cyc++;
    end
  end

  task automatic drive_bit(input bit b);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_bit   = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) check("accept_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FL-1:0] bits, input int drop_after,
                            input int drop_len, input bit rnd_gaps);
    for (int i = 0; i < FL; i++) begin
      drive_bit(bits[FL-1-i]);
      if (i + 1 == drop_after) idle(drop_len);
      if (rnd_gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end
  endtask

  task automatic wait_frames(input int n);
    int guard;
    guard = 0;
    while (frames_done < n && guard < 400) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("frames_done", 32'(frames_done), 32'(n));
  endtask

  localparam logic [FL-1:0] F1      = 14'b10010100101100;
  localparam logic [FL-1:0] F_ONES  = 14'h3FFF;
  localparam logic [FL-1:0] F_IMPUL = 14'b10000000000000;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy",      32'(busy),      32'd0);
    #9 reset = 1'b1;
    #1;
    check("reset_in_ready",  32'(in_ready),  32'd1);
    check("reset_out_sof",   32'(out_sof),   32'd0);

    // Basic frame.
    @(posedge clk); #1;
    send_frame(F1, 0, 0, 0);
    idle(1);
    wait_frames(1);
    check("frame1_bits", last_frame, 32'hEF8BE170);
    check("frame1_len",  32'(last_len), 32'd32);

    // Two frames back to back with in_valid high through the tails.
    @(posedge clk); #1;
    send_frame(F1, 0, 0, 0);
    send_frame(F1, 0, 0, 0);
    idle(1);
    wait_frames(3);
    check("b2b_bits", last_frame, 32'hEF8BE170);
    check("b2b_gap",  32'(last_gap), 32'd1);

    // Starvation after bit 5.
    @(posedge clk); #1;
    send_frame(F1, 5, 5, 0);
    idle(1);
    wait_frames(4);
    check("starve_bits", last_frame, 32'hEF8BE170);
    check("starve_idle", 32'(last_idle), 32'd4);

    // Asynchronous reset in E1 of bit 7.
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) drive_bit(F1[FL-1-i]);
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    check("pre_reset_busy",  32'(busy),      32'd1);
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_busy",      32'(busy),      32'd0);
    check("async_out_sof",   32'(out_sof),   32'd0);
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    send_frame(F_ONES, 0, 0, 0);
    idle(1);
    wait_frames(5);
    check("ones_bits", last_frame, 32'hDAAAAAA7);

    // Impulse response.
    @(posedge clk); #1;
    send_frame(F_IMPUL, 0, 0, 0);
    idle(1);
    wait_frames(6);
    check("impulse_bits", last_frame, 32'hEC000000);
    check("impulse_len",  32'(last_len), 32'd32);

    // Random frames with random in_valid gaps, checked cycle by cycle.
    @(posedge clk); #1;
    for (int f = 0; f < 8; f++) begin
      send_frame(FL'($urandom), 0, 0, 1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(2);
    wait_frames(14);
    check("random_len", 32'(last_len), 32'd32);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
